// File: rtl/vga_anim_pkg.sv
// Shared types and defaults for the sprite animation block: sweep FSM encoding
// and the per-axis {position, direction} state.
package vga_anim_pkg;

  localparam int unsigned DEF_COORD_W = 12;
  localparam int unsigned DEF_STEP_W  = 4;
  // Axis positions are carried at a fixed width; instances with a narrower
  // COORD_W keep the upper bits at zero.
  localparam int unsigned AXIS_W      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } sweep_st_e;

  typedef struct packed {
    logic [AXIS_W-1:0] pos;
    logic              dir;
  } axis_t;

endpackage

// File: rtl/bounce_axis_step.sv
// Combinational single-axis bounce step: moves pos by speed in direction dir,
// clamping to [0, max] and flipping direction when a bound is reached.
module bounce_axis_step
  import vga_anim_pkg::*;
#(
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  axis_t             i_cur,
  input  logic [STEP_W-1:0] i_speed,
  input  logic [AXIS_W-1:0] i_max,
  output axis_t             o_nxt
);

  logic [AXIS_W:0] spd_ext;
  logic [AXIS_W:0] sum;

  // One extra bit on the sum so a step past the right/bottom bound never wraps.
  assign spd_ext = {{(AXIS_W + 1 - STEP_W){1'b0}}, i_speed};
  assign sum     = {1'b0, i_cur.pos} + spd_ext;

  always_comb begin
    o_nxt = i_cur;
    if (i_cur.dir) begin
      if (sum >= {1'b0, i_max}) begin
        o_nxt.pos = i_max;
        o_nxt.dir = 1'b0;
      end else begin
        o_nxt.pos = sum[AXIS_W-1:0];
      end
    end else begin
      if ({1'b0, i_cur.pos} <= spd_ext) begin
        o_nxt.pos = '0;
        o_nxt.dir = 1'b1;
      end else begin
        o_nxt.pos = i_cur.pos - spd_ext[AXIS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_bounce_array.sv
// N bouncing sprites updated one per clock after each animation strobe.
// Define OBJ_HIT_EN to build the registered per-object pixel hit comparators.
module sprite_bounce_array
  import vga_anim_pkg::*;
#(
  parameter int unsigned N_OBJ    = 4,
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned STEP_W   = DEF_STEP_W,
  parameter int unsigned OBJ_W    = 32,
  parameter int unsigned OBJ_H    = 32,
  parameter int unsigned IX       = 16,
  parameter int unsigned IY       = 16,
  parameter int unsigned SEP_X    = 96,
  parameter int unsigned SEP_Y    = 64,
  parameter int unsigned D_WIDTH  = 640,
  parameter int unsigned D_HEIGHT = 480,
  localparam int unsigned IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ani_stb,
  input  logic                       i_animate,
  input  logic                       i_cfg_we,
  input  logic [IDX_W-1:0]           i_cfg_idx,
  input  logic [STEP_W-1:0]          i_cfg_sx,
  input  logic [STEP_W-1:0]          i_cfg_sy,
  input  logic [COORD_W-1:0]         i_px,
  input  logic [COORD_W-1:0]         i_py,
  output logic [N_OBJ*COORD_W-1:0]   o_x1,
  output logic [N_OBJ*COORD_W-1:0]   o_x2,
  output logic [N_OBJ*COORD_W-1:0]   o_y1,
  output logic [N_OBJ*COORD_W-1:0]   o_y2,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_overrun,
  output logic [N_OBJ-1:0]           o_hit
);

  localparam logic [AXIS_W-1:0] XMAX = AXIS_W'(D_WIDTH - OBJ_W);
  localparam logic [AXIS_W-1:0] YMAX = AXIS_W'(D_HEIGHT - OBJ_H);

  sweep_st_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;
  axis_t             ax_q [N_OBJ];
  axis_t             ax_d [N_OBJ];
  axis_t             ay_q [N_OBJ];
  axis_t             ay_d [N_OBJ];
  logic [STEP_W-1:0] sx_q [N_OBJ];
  logic [STEP_W-1:0] sx_d [N_OBJ];
  logic [STEP_W-1:0] sy_q [N_OBJ];
  logic [STEP_W-1:0] sy_d [N_OBJ];
  axis_t             nx, ny;
  logic              busy;
  logic              cfg_valid;

  assign busy      = (state_q != StIdle);
  assign cfg_valid = (32'(i_cfg_idx) < N_OBJ);

  bounce_axis_step #(
    .STEP_W (STEP_W)
  ) u_step_x (
    .i_cur   (ax_q[idx_q]),
    .i_speed (sx_q[idx_q]),
    .i_max   (XMAX),
    .o_nxt   (nx)
  );

  bounce_axis_step #(
    .STEP_W (STEP_W)
  ) u_step_y (
    .i_cur   (ay_q[idx_q]),
    .i_speed (sy_q[idx_q]),
    .i_max   (YMAX),
    .o_nxt   (ny)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    overrun_d = overrun_q | (i_ani_stb & i_animate & busy);
    case (state_q)
      StIdle: begin
        if (i_ani_stb && i_animate) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        ax_d[idx_q] = nx;
        ay_d[idx_q] = ny;
        if (idx_q == IDX_W'(N_OBJ - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // The sweep above already consumed the old speed, so a same-cycle write
    // only takes effect on the next frame.
    if (i_cfg_we && cfg_valid) begin
      sx_d[i_cfg_idx] = i_cfg_sx;
      sy_d[i_cfg_idx] = i_cfg_sy;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < int'(N_OBJ); k++) begin
        ax_q[k] <= '{pos: AXIS_W'(IX + k * SEP_X), dir: ~k[0]};
        ay_q[k] <= '{pos: AXIS_W'(IY + k * SEP_Y), dir: 1'b1};
        sx_q[k] <= STEP_W'(1);
        sy_q[k] <= STEP_W'(1);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
    end
  end

  always_comb begin
    o_x1 = '0;
    o_x2 = '0;
    o_y1 = '0;
    o_y2 = '0;
    for (int k = 0; k < int'(N_OBJ); k++) begin
      o_x1[k*COORD_W +: COORD_W] = ax_q[k].pos[COORD_W-1:0];
      o_x2[k*COORD_W +: COORD_W] = ax_q[k].pos[COORD_W-1:0] + COORD_W'(OBJ_W);
      o_y1[k*COORD_W +: COORD_W] = ay_q[k].pos[COORD_W-1:0];
      o_y2[k*COORD_W +: COORD_W] = ay_q[k].pos[COORD_W-1:0] + COORD_W'(OBJ_H);
    end
  end

  assign o_busy       = busy;
  assign o_frame_done = (state_q == StDone);
  assign o_overrun    = overrun_q;

`ifdef OBJ_HIT_EN
  logic [N_OBJ-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = '0;
    for (int k = 0; k < int'(N_OBJ); k++) begin
      hit_d[k] = (i_px >= o_x1[k*COORD_W +: COORD_W]) && (i_px < o_x2[k*COORD_W +: COORD_W]) &&
                 (i_py >= o_y1[k*COORD_W +: COORD_W]) && (i_py < o_y2[k*COORD_W +: COORD_W]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign o_hit = hit_q;
`else
  logic unused_pix;
  assign unused_pix = ^{i_px, i_py};
  assign o_hit      = '0;
`endif

endmodule

// File: tb/tb_sprite_bounce_array.sv
// Directed bench for sprite_bounce_array with a reference model feeding a
// frame scoreboard that is checked on every o_frame_done pulse.
module tb_sprite_bounce_array;

  localparam int N  = 4;
  localparam int CW = 12;
  localparam int OW = 32;
  localparam int OH = 32;
  localparam int XM = 640 - 32;
  localparam int YM = 480 - 32;

  typedef struct packed {
    logic [N*CW-1:0] x1;
    logic [N*CW-1:0] x2;
    logic [N*CW-1:0] y1;
    logic [N*CW-1:0] y2;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ani_stb = 1'b0;
  logic            animate = 1'b1;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_idx = '0;
  logic [3:0]      cfg_sx = '0;
  logic [3:0]      cfg_sy = '0;
  logic [CW-1:0]   px = '0;
  logic [CW-1:0]   py = '0;
  logic [N*CW-1:0] x1, x2, y1, y2;
  logic            busy, frame_done, overrun;
  logic [N-1:0]    hit;

  int     mx [N];
  int     my [N];
  int     mdx [N];
  int     mdy [N];
  int     msx [N];
  int     msy [N];
  frame_t sb [$];
  int     n_cmp = 0;
  int     n_err = 0;

  sprite_bounce_array dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ani_stb    (ani_stb),
    .i_animate    (animate),
    .i_cfg_we     (cfg_we),
    .i_cfg_idx    (cfg_idx),
    .i_cfg_sx     (cfg_sx),
    .i_cfg_sy     (cfg_sy),
    .i_px         (px),
    .i_py         (py),
    .o_x1         (x1),
    .o_x2         (x2),
    .o_y1         (y1),
    .o_y2         (y2),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_overrun    (overrun),
    .o_hit        (hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int step_pos(input int p, input int d, input int s, input int m);
    if (d != 0) return (p + s >= m) ? m : p + s;
    return (p <= s) ? 0 : p - s;
  endfunction

  function automatic int step_dir(input int p, input int d, input int s, input int m);
    if (d != 0) return (p + s >= m) ? 0 : 1;
    return (p <= s) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k]  = 16 + k * 96;
      my[k]  = 16 + k * 64;
      mdx[k] = (k % 2 == 0) ? 1 : 0;
      mdy[k] = 1;
      msx[k] = 1;
      msy[k] = 1;
    end
    sb.delete();
  endtask

  function automatic frame_t snap();
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f.x1[k*CW +: CW] = CW'(mx[k]);
      f.x2[k*CW +: CW] = CW'(mx[k] + OW);
      f.y1[k*CW +: CW] = CW'(my[k]);
      f.y2[k*CW +: CW] = CW'(my[k] + OH);
    end
    return f;
  endfunction

  task automatic model_frame();
    int nx, ndx, ny, ndy;
    for (int k = 0; k < N; k++) begin
      nx  = step_pos(mx[k], mdx[k], msx[k], XM);
      ndx = step_dir(mx[k], mdx[k], msx[k], XM);
      ny  = step_pos(my[k], mdy[k], msy[k], YM);
      ndy = step_dir(my[k], mdy[k], msy[k], YM);
      mx[k] = nx; mdx[k] = ndx; my[k] = ny; mdy[k] = ndy;
    end
    sb.push_back(snap());
  endtask

  task automatic cmp_edges(input string tag, input frame_t e);
    chk({tag, "_x1"}, 64'(x1), 64'(e.x1));
    chk({tag, "_x2"}, 64'(x2), 64'(e.x2));
    chk({tag, "_y1"}, 64'(y1), 64'(e.y1));
    chk({tag, "_y2"}, 64'(y2), 64'(e.y2));
  endtask

  task automatic check_frame();
    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) cmp_edges("frame", sb.pop_front());
  endtask

  task automatic cfg(input int idx, input int sx, input int sy);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_sx = 4'(sx); cfg_sy = 4'(sy);
    tick();
    cfg_we = 1'b0;
    msx[idx] = sx; msy[idx] = sy;
  endtask

  // Cycle c = 1 is the first sweep cycle; stb_at/rst_at/wr_at drive inputs
  // during that cycle (0 = unused). The mid-sweep write targets object 2 with sx=7.
  task automatic run_frame(input int stb_at, input int rst_at, input int wr_at);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    model_frame();
    ani_stb = 1'b1;
    tick();
    ani_stb = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_at = c;
        check_frame();
      end
      ani_stb = (c == stb_at);
      rst     = (c == rst_at);
      if (c == wr_at) begin
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_sx = 4'd7; cfg_sy = 4'd1;
      end
      tick();
      ani_stb = 1'b0;
      if (cfg_we) begin
        cfg_we = 1'b0; msx[2] = 7; msy[2] = 1;
      end
      if (rst) begin
        rst = 1'b0;
        model_reset();
        break;
      end
    end
    if (rst_at == 0) begin
      chk("busy_cycles", 64'(busy_cnt), 64'(N + 1));
      chk("done_count", 64'(done_cnt), 64'(1));
      chk("done_cycle", 64'(done_at), 64'(N + 1));
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (frame_done) done_cnt++;
        tick();
      end
      chk("no_done_after_rst", 64'(done_cnt), 64'(0));
    end
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_obj1_x1", 64'(x1[CW +: CW]), 64'(112));
    chk("rst_obj1_y1", 64'(y1[CW +: CW]), 64'(80));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_hit", 64'(hit), 64'(0));
    cmp_edges("rst", snap());

    // Single strobe: obj1 moves left (dx=0 at reset), obj0 to (17,17)
    run_frame(0, 0, 0);
    chk("f1_obj0_x1", 64'(x1[0 +: CW]), 64'(17));
    chk("f1_obj0_y1", 64'(y1[0 +: CW]), 64'(17));
    chk("f1_obj1_x1", 64'(x1[CW +: CW]), 64'(111));

    // Right-edge clamp: drive obj0 to x=606, then step 4 -> 608, then 604
    cfg(0, 9, 1);
    run_frame(0, 0, 0);
    cfg(0, 10, 1);
    for (int i = 0; i < 58; i++) run_frame(0, 0, 0);
    chk("obj0_x_606", 64'(x1[0 +: CW]), 64'(606));
    cfg(0, 4, 1);
    run_frame(0, 0, 0);
    chk("obj0_clamp_608", 64'(x1[0 +: CW]), 64'(608));
    chk("obj0_x2_640", 64'(x2[0 +: CW]), 64'(640));
    run_frame(0, 0, 0);
    chk("obj0_back_604", 64'(x1[0 +: CW]), 64'(604));

    // Left-edge clamp: bring obj0 to x=3 moving left, then step 4 -> 0
    cfg(0, 15, 1);
    for (int i = 0; i < 40; i++) run_frame(0, 0, 0);
    chk("obj0_x_4", 64'(x1[0 +: CW]), 64'(4));
    cfg(0, 1, 1);
    run_frame(0, 0, 0);
    chk("obj0_x_3", 64'(x1[0 +: CW]), 64'(3));
    cfg(0, 4, 1);
    run_frame(0, 0, 0);
    chk("obj0_clamp_0", 64'(x1[0 +: CW]), 64'(0));

    // Speed write to obj2 while it is being swept: old speed this frame, 7 next
    run_frame(0, 0, 3);
    chk("obj0_bounce_4", 64'(x1[0 +: CW]), 64'(4));
    run_frame(0, 0, 0);

    // Strobe during sweep: overrun, no extra sweep
    run_frame(2, 0, 0);
    chk("overrun_set", 64'(overrun), 64'(1));
    tick();
    chk("no_extra_sweep", 64'(busy), 64'(0));

    // Reset mid-sweep: state back to initial, no done pulse, overrun cleared
    run_frame(0, 3, 0);
    chk("rst_mid_overrun", 64'(overrun), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    cmp_edges("rst_mid", snap());

    // Animate low: strobe ignored without overrun
    animate = 1'b0;
    ani_stb = 1'b1;
    tick();
    ani_stb = 1'b0;
    chk("anim_off_busy", 64'(busy), 64'(0));
    chk("anim_off_overrun", 64'(overrun), 64'(0));
    animate = 1'b1;

    // Pixel hit against obj0 at (16,16)
    px = 12'd16; py = 12'd16;
    tick();
`ifdef OBJ_HIT_EN
    chk("hit_inside", 64'(hit), 64'(4'b0001));
`else
    chk("hit_tied_off", 64'(hit), 64'(0));
`endif
    px = 12'd48;
    tick();
    chk("hit_excl_edge", 64'(hit), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
